// File: rtl/uart_transmit.sv
// UART transmitter: one-byte holding register feeding an 11-bit frame shifter.
// Every frame is start + data + fill bits; each bit is held for k clk cycles.
module uart_transmit #(
  parameter int K_W = 19
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [K_W-1:0] k,
  input  logic           EIGHT,
  input  logic           PEN,
  input  logic           OHEL,
  input  logic           LOAD,
  input  logic [7:0]     OUT_PORT,
  output logic           TX,
  output logic           TX_RDY,
  output logic           TX_BUSY,
  output logic           state_dbg
);

  // Handshake: a byte is taken on any rising edge where LOAD=1 and TX_RDY=1.
  // LOAD while TX_RDY=0 is dropped (not held off); the sender must retry.

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state_q, state_d;

  logic           hold_empty;
  logic [7:0]     hold_data;
  logic           hold_eight, hold_pen, hold_ohel;

  logic [10:0]    shift_q;
  logic [3:0]     bit_cnt;
  logic [K_W-1:0] time_cnt;
  logic [K_W-1:0] bit_len_m1;

  logic           accept, bit_tick, frame_end, load_shift;
  logic [K_W-1:0] k_m1;

  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic eight,
                                              input logic pen, input logic ohel);
    logic        par;
    logic [10:0] f;
    if (eight) begin
      par = (^d) ^ ohel;
      f   = {1'b1, (pen ? par : 1'b1), d, 1'b0};
    end else begin
      par = (^d[6:0]) ^ ohel;
      f   = {2'b11, (pen ? par : 1'b1), d[6:0], 1'b0};
    end
    return f;
  endfunction

  always_comb begin
    accept     = LOAD & hold_empty;
    bit_tick   = (state_q == SEND) && (time_cnt == bit_len_m1);
    frame_end  = bit_tick && (bit_cnt == 4'd10);
    load_shift = !hold_empty && ((state_q == IDLE) || frame_end);
    // k=0 behaves as k=1, so the terminal count never underflows.
    k_m1       = (k == '0) ? '0 : k - K_W'(1);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (!hold_empty) state_d = SEND;
      SEND:    if (frame_end && hold_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_empty <= 1'b1;
      hold_data  <= '0;
      hold_eight <= 1'b0;
      hold_pen   <= 1'b0;
      hold_ohel  <= 1'b0;
    end else if (accept) begin
      hold_empty <= 1'b0;
      hold_data  <= OUT_PORT;
      hold_eight <= EIGHT;
      hold_pen   <= PEN;
      hold_ohel  <= OHEL;
    end else if (load_shift) begin
      hold_empty <= 1'b1;
    end
  end

  // Frame format is fixed at transfer time; only k is re-sampled per bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '1;
      bit_cnt    <= '0;
      time_cnt   <= '0;
      bit_len_m1 <= '0;
    end else if (load_shift) begin
      shift_q    <= build_frame(hold_data, hold_eight, hold_pen, hold_ohel);
      bit_cnt    <= '0;
      time_cnt   <= '0;
      bit_len_m1 <= k_m1;
    end else if (bit_tick) begin
      time_cnt <= '0;
      if (frame_end) begin
        shift_q <= '1;
        bit_cnt <= '0;
      end else begin
        shift_q    <= {1'b1, shift_q[10:1]};
        bit_cnt    <= bit_cnt + 4'd1;
        bit_len_m1 <= k_m1;
      end
    end else if (state_q == SEND) begin
      time_cnt <= time_cnt + K_W'(1);
    end
  end

  assign TX        = (state_q == SEND) ? shift_q[0] : 1'b1;
  assign TX_BUSY   = (state_q == SEND);
  assign TX_RDY    = hold_empty;
  assign state_dbg = state_q;

endmodule
